// File: rtl/rfu.sv
// rfu: register-fetch stage owning the GPR file and machine CSRs, feeding the deu bus
module rfu #(
    parameter int NR_GPR = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ifu_valid_i,
    input  logic [31:0]  ifu_pc_i,
    input  logic [31:0]  ifu_inst_i,
    input  logic         wb_valid_i,
    input  logic         wb_gr_we_i,
    input  logic [4:0]   wb_rd_i,
    input  logic [31:0]  wb_wdata_i,
    input  logic         wb_csr_we_i,
    input  logic [11:0]  wb_csr_addr_i,
    input  logic [31:0]  wb_csr_wdata_i,
    input  logic         wb_excp_i,
    input  logic         wb_xret_i,
    input  logic [31:0]  wb_pc_i,
    output logic [191:0] rfu_deu_bus_o,
    output logic         valid_o,
    output logic [31:0]  csr_mtvec_o,
    output logic [31:0]  csr_mepc_o
);
    localparam int IW = $clog2(NR_GPR);

    logic [31:0] gpr [NR_GPR];
    logic [31:0] mstatus, mtvec, mepc, mcause;
    logic [31:0] mstatus_n, mtvec_n, mepc_n, mcause_n;
    logic [31:0] rs1_value, rs2_value, csr_value;
    logic        gr_we, csr_we, excp, xret;

    assign gr_we  = wb_valid_i && wb_gr_we_i && wb_rd_i != 5'd0 && int'(wb_rd_i) < NR_GPR;
    assign csr_we = wb_valid_i && wb_csr_we_i;
    assign excp   = wb_valid_i && wb_excp_i;
    assign xret   = wb_valid_i && wb_xret_i && !wb_excp_i;

    assign csr_mtvec_o = mtvec;
    assign csr_mepc_o  = mepc;

    function automatic logic [31:0] gpr_read(input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= NR_GPR) return 32'd0;
        if (gr_we && wb_rd_i == idx) return wb_wdata_i;
        return gpr[idx[IW-1:0]];
    endfunction

    // Next CSR state: the software write lands first, then mret/ecall override only the fields they own
    always_comb begin
        mstatus_n = csr_we && wb_csr_addr_i == 12'h300 ? wb_csr_wdata_i | 32'h0000_1800 : mstatus;
        mtvec_n   = csr_we && wb_csr_addr_i == 12'h305 ? wb_csr_wdata_i : mtvec;
        mepc_n    = excp ? wb_pc_i : csr_we && wb_csr_addr_i == 12'h341 ? wb_csr_wdata_i : mepc;
        mcause_n  = excp ? 32'd11 : csr_we && wb_csr_addr_i == 12'h342 ? wb_csr_wdata_i : mcause;
        if (excp) begin
            mstatus_n[7] = mstatus[3];
            mstatus_n[3] = 1'b0;
        end else if (xret) begin
            mstatus_n[3] = mstatus[7];
            mstatus_n[7] = 1'b1;
        end
    end

    // Operand reads; CSR reads see the next state so a same-cycle write is bypassed
    always_comb begin
        rs1_value = gpr_read(ifu_inst_i[19:15]);
        rs2_value = gpr_read(ifu_inst_i[24:20]);
        csr_value = ifu_inst_i[31:20] == 12'h300 ? mstatus_n :
                    ifu_inst_i[31:20] == 12'h305 ? mtvec_n :
                    ifu_inst_i[31:20] == 12'h341 ? mepc_n :
                    ifu_inst_i[31:20] == 12'h342 ? mcause_n : 32'd0;
    end

    // Capture the deu bus on each fetch pulse; valid is a one-cycle echo of the pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_o       <= 1'b0;
            rfu_deu_bus_o <= '0;
        end else begin
            valid_o <= ifu_valid_i;
            if (ifu_valid_i)
                rfu_deu_bus_o <= {ifu_pc_i + 32'd4, ifu_pc_i, ifu_inst_i, rs1_value, rs2_value, csr_value};
        end
    end

    // Architectural state: CSRs and GPR write-back
    always_ff @(posedge clock) begin
        if (reset) begin
            mstatus <= 32'h0000_1800;
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
            for (int i = 0; i < NR_GPR; i++) gpr[i] <= '0;
        end else begin
            mstatus <= mstatus_n;
            mtvec   <= mtvec_n;
            mepc    <= mepc_n;
            mcause  <= mcause_n;
            if (gr_we) gpr[wb_rd_i[IW-1:0]] <= wb_wdata_i;
        end
    end
endmodule

// File: tb/tb_rfu.sv
// tb_rfu: directed and random checks of rfu (32 and 16 GPR builds) against a behavioural model
module tb_rfu;
    logic         clock = 1'b0, reset = 1'b1;
    logic         ifu_valid = 1'b0, wb_valid = 1'b0, wb_gr_we = 1'b0, wb_csr_we = 1'b0, wb_excp = 1'b0, wb_xret = 1'b0;
    logic [31:0]  ifu_pc = '0, ifu_inst = '0, wb_wdata = '0, wb_csr_wdata = '0, wb_pc = '0;
    logic [4:0]   wb_rd = '0;
    logic [11:0]  wb_csr_addr = '0;
    logic [191:0] bus32, bus16;
    logic         v32, v16;
    logic [31:0]  mtvec32, mepc32, mtvec16, mepc16;

    rfu #(.NR_GPR(32)) dut (
        .clock(clock), .reset(reset), .ifu_valid_i(ifu_valid), .ifu_pc_i(ifu_pc), .ifu_inst_i(ifu_inst),
        .wb_valid_i(wb_valid), .wb_gr_we_i(wb_gr_we), .wb_rd_i(wb_rd), .wb_wdata_i(wb_wdata),
        .wb_csr_we_i(wb_csr_we), .wb_csr_addr_i(wb_csr_addr), .wb_csr_wdata_i(wb_csr_wdata),
        .wb_excp_i(wb_excp), .wb_xret_i(wb_xret), .wb_pc_i(wb_pc),
        .rfu_deu_bus_o(bus32), .valid_o(v32), .csr_mtvec_o(mtvec32), .csr_mepc_o(mepc32)
    );

    rfu #(.NR_GPR(16)) dut16 (
        .clock(clock), .reset(reset), .ifu_valid_i(ifu_valid), .ifu_pc_i(ifu_pc), .ifu_inst_i(ifu_inst),
        .wb_valid_i(wb_valid), .wb_gr_we_i(wb_gr_we), .wb_rd_i(wb_rd), .wb_wdata_i(wb_wdata),
        .wb_csr_we_i(wb_csr_we), .wb_csr_addr_i(wb_csr_addr), .wb_csr_wdata_i(wb_csr_wdata),
        .wb_excp_i(wb_excp), .wb_xret_i(wb_xret), .wb_pc_i(wb_pc),
        .rfu_deu_bus_o(bus16), .valid_o(v16), .csr_mtvec_o(mtvec16), .csr_mepc_o(mepc16)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;
    logic [31:0]  g32 [32];
    logic [31:0]  g16 [16];
    logic [31:0]  ms, mt, me, mc;
    logic [191:0] e32, e16;
    logic         ev;
    logic [11:0]  csrs [5] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0};

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gr(input int nr, input logic [4:0] r);
        if (r == 5'd0 || int'(r) >= nr) return 32'd0;
        if (wb_valid && wb_gr_we && wb_rd == r) return wb_wdata;
        return nr == 32 ? g32[r] : g16[r[3:0]];
    endfunction

    task automatic idle();
        ifu_valid = 0; wb_valid = 0; wb_gr_we = 0; wb_csr_we = 0; wb_excp = 0; wb_xret = 0; reset = 0;
    endtask

    task automatic step();
        logic [31:0] nms, nmt, nme, nmc, cv;
        if (reset) begin
            for (int i = 0; i < 32; i++) g32[i] = '0;
            for (int i = 0; i < 16; i++) g16[i] = '0;
            ms = 32'h0000_1800; mt = '0; me = '0; mc = '0;
            ev = 0; e32 = '0; e16 = '0;
        end else begin
            nms = ms; nmt = mt; nme = me; nmc = mc;
            if (wb_valid && wb_csr_we) begin
                if (wb_csr_addr == 12'h300) nms = wb_csr_wdata | 32'h0000_1800;
                if (wb_csr_addr == 12'h305) nmt = wb_csr_wdata;
                if (wb_csr_addr == 12'h341) nme = wb_csr_wdata;
                if (wb_csr_addr == 12'h342) nmc = wb_csr_wdata;
            end
            if (wb_valid && wb_excp) begin
                nme = wb_pc; nmc = 32'd11; nms[7] = ms[3]; nms[3] = 1'b0;
            end else if (wb_valid && wb_xret) begin
                nms[3] = ms[7]; nms[7] = 1'b1;
            end
            case (ifu_inst[31:20])
                12'h300: cv = nms;
                12'h305: cv = nmt;
                12'h341: cv = nme;
                12'h342: cv = nmc;
                default: cv = 32'd0;
            endcase
            ev = ifu_valid;
            if (ifu_valid) begin
                e32 = {ifu_pc + 32'd4, ifu_pc, ifu_inst, gr(32, ifu_inst[19:15]), gr(32, ifu_inst[24:20]), cv};
                e16 = {ifu_pc + 32'd4, ifu_pc, ifu_inst, gr(16, ifu_inst[19:15]), gr(16, ifu_inst[24:20]), cv};
            end
            if (wb_valid && wb_gr_we && wb_rd != 5'd0) begin
                g32[wb_rd] = wb_wdata;
                if (wb_rd < 5'd16) g16[wb_rd[3:0]] = wb_wdata;
            end
            ms = nms; mt = nmt; me = nme; mc = nmc;
        end
        @(posedge clock);
        #1;
        check("valid32", 192'(v32), 192'(ev));
        check("valid16", 192'(v16), 192'(ev));
        check("bus32", bus32, e32);
        check("bus16", bus16, e16);
        check("mtvec32", 192'(mtvec32), 192'(mt));
        check("mepc32", 192'(mepc32), 192'(me));
        check("mtvec16", 192'(mtvec16), 192'(mt));
        check("mepc16", 192'(mepc16), 192'(me));
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        ifu_valid = 1; ifu_pc = pc; ifu_inst = inst;
    endtask

    task automatic wbg(input logic [4:0] rd, input logic [31:0] d);
        wb_valid = 1; wb_gr_we = 1; wb_rd = rd; wb_wdata = d;
    endtask

    initial begin
        reset = 1;
        step();
        step();
        check("rst_valid", 192'(v32), 192'(0));
        check("rst_bus", bus32, 192'(0));
        check("rst_mtvec", 192'(mtvec32), 192'(0));
        idle(); fetch(32'h0, 32'h3000_2073); step();
        check("rst_mstatus", 192'(bus32[31:0]), 192'(32'h0000_1800));

        idle(); wbg(5'd5, 32'hDEAD_BEEF); step();
        idle(); fetch(32'h8000_0000, 32'h0002_8093); step();
        check("x5_valid", 192'(v32), 192'(1));
        check("x5_rs1", 192'(bus32[95:64]), 192'(32'hDEAD_BEEF));
        check("x5_snpc", 192'(bus32[191:160]), 192'(32'h8000_0004));
        idle(); step();
        check("valid_drop", 192'(v32), 192'(0));
        check("bus_hold", 192'(bus32[95:64]), 192'(32'hDEAD_BEEF));

        idle(); wbg(5'd6, 32'h1234); fetch(32'h8000_0008, 32'h0063_00B3); step();
        check("byp_rs1", 192'(bus32[95:64]), 192'(32'h1234));
        check("byp_rs2", 192'(bus32[63:32]), 192'(32'h1234));

        idle(); wbg(5'd0, 32'hFFFF_FFFF); step();
        idle(); fetch(32'h8000_000C, 32'h0000_0093); step();
        check("x0_rs1", 192'(bus32[95:64]), 192'(0));
        idle(); wbg(5'd20, 32'h0000_CAFE); step();
        idle(); fetch(32'h8000_0010, 32'h000A_0093); step();
        check("x20_rv32", 192'(bus32[95:64]), 192'(32'h0000_CAFE));
        check("x20_rv32e", 192'(bus16[95:64]), 192'(0));

        reset = 1; step();
        idle(); wb_valid = 1; wb_excp = 1; wb_pc = 32'h8000_0100; step();
        check("ecall_mepc", 192'(mepc32), 192'(32'h8000_0100));
        idle(); fetch(32'h0, 32'h3420_2073); step();
        check("ecall_mcause", 192'(bus32[31:0]), 192'(11));
        idle(); fetch(32'h0, 32'h3000_2073); step();
        check("ecall_mstatus", 192'(bus32[31:0]), 192'(32'h0000_1800));
        idle(); wb_valid = 1; wb_xret = 1; step();
        idle(); fetch(32'h0, 32'h3000_2073); step();
        check("mret_mstatus", 192'(bus32[31:0]), 192'(32'h0000_1880));

        idle(); wb_valid = 1; wb_csr_we = 1; wb_csr_addr = 12'h305; wb_csr_wdata = 32'h8000_0200; step();
        idle(); fetch(32'h0, 32'h3050_2073); step();
        check("mtvec_csr", 192'(bus32[31:0]), 192'(32'h8000_0200));
        check("mtvec_port", 192'(mtvec32), 192'(32'h8000_0200));
        idle(); fetch(32'h0, 32'h7C00_2073); step();
        check("csr_unmapped", 192'(bus32[31:0]), 192'(0));

        for (int k = 0; k < 3; k++) begin
            idle(); fetch(32'h9000_0000 + 32'(k * 4), $urandom); step();
            check("burst_valid", 192'(v32), 192'(1));
        end
        reset = 1; step();
        check("rst_mid_valid", 192'(v32), 192'(0));
        check("rst_mid_bus", bus32, 192'(0));

        for (int k = 0; k < 500; k++) begin
            reset = $urandom_range(0, 49) == 0;
            ifu_valid = $urandom_range(0, 2) != 0;
            ifu_pc = $urandom;
            ifu_inst = $urandom;
            ifu_inst[31:20] = $urandom_range(0, 3) == 0 ? 12'($urandom) : csrs[$urandom_range(0, 4)];
            wb_valid = $urandom_range(0, 3) != 0;
            wb_gr_we = $urandom_range(0, 1) == 1;
            wb_rd = 5'($urandom);
            wb_wdata = $urandom;
            if ($urandom_range(0, 3) == 0) ifu_inst[19:15] = wb_rd;
            if ($urandom_range(0, 3) == 0) ifu_inst[24:20] = wb_rd;
            wb_csr_we = $urandom_range(0, 2) == 0;
            wb_csr_addr = csrs[$urandom_range(0, 4)];
            wb_csr_wdata = $urandom;
            wb_excp = $urandom_range(0, 5) == 0;
            wb_xret = $urandom_range(0, 5) == 0;
            wb_pc = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
